// File: rtl/oc4_vc_credit_bridge.sv
// Credit-managed bridge for one OCSE4 TLX->AFU virtual channel into an OCSE3-style AFU receive port.
// Upstream beats are buffered in a DEPTH-entry FIFO. A beat is forwarded only while AFU credits remain.
// Upstream credits are returned one per freed FIFO slot.
module oc4_vc_credit_bridge #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CRED_W = 7
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         tlx_bb_valid,
    input  logic [DATA_W-1:0]            tlx_bb_payload,
    output logic [CRED_W-1:0]            bb_tlx_initial_credit,
    output logic                         bb_tlx_credit,
    input  logic [CRED_W-1:0]            afu_bb_initial_credit,
    input  logic                         afu_bb_credit,
    output logic                         bb_afu_valid,
    output logic [DATA_W-1:0]            bb_afu_payload,
    input  logic                         cfg_resync_credits,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow_err,
    output logic                         credit_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CRED_W-1:0]   afu_cred;

    logic pop_c;
    logic push_c;
    logic ovf_c;
    logic cred_ret_c;
    logic cred_sat_c;
    logic cred_inc_c;

    // The upstream grant is simply the buffer size
    assign bb_tlx_initial_credit = CRED_W'(DEPTH);

    // Issue, push acceptance and credit bookkeeping decisions for this cycle
    always_comb begin
        pop_c      = 1'b0;
        push_c     = 1'b0;
        ovf_c      = 1'b0;
        cred_ret_c = 1'b0;
        cred_sat_c = 1'b0;
        cred_inc_c = 1'b0;

        pop_c  = (state == ST_RUN) && (fifo_count != '0) && (afu_cred != '0);
        push_c = tlx_bb_valid && (state != ST_IDLE) && ((fifo_count != FULL_CNT) || pop_c);
        ovf_c  = tlx_bb_valid && (state != ST_IDLE) && (fifo_count == FULL_CNT) && !pop_c;

        // Returns count only in RUN/HOLD; LOAD overwrites the counter anyway
        cred_ret_c = afu_bb_credit && ((state == ST_RUN) || (state == ST_HOLD));
        cred_sat_c = cred_ret_c && !pop_c && (afu_cred == CRED_MAX);
        cred_inc_c = cred_ret_c && !cred_sat_c;
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = ST_LOAD;
            ST_LOAD: state_next = ST_RUN;
            ST_RUN:  if (cfg_resync_credits) state_next = ST_HOLD;
            ST_HOLD: if (!cfg_resync_credits) state_next = ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are discarded logically by the pointer reset
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= tlx_bb_payload;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered downstream beat and the matching upstream credit pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bb_afu_valid   <= 1'b0;
            bb_afu_payload <= '0;
            bb_tlx_credit  <= 1'b0;
        end else begin
            bb_afu_valid  <= pop_c;
            bb_tlx_credit <= pop_c;
            if (pop_c) begin
                bb_afu_payload <= mem[rd_ptr];
            end
        end
    end

    // AFU credit counter: reload in LOAD, otherwise +return -issue with saturation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            afu_cred <= '0;
        end else if (state == ST_LOAD) begin
            afu_cred <= afu_bb_initial_credit;
        end else if (cred_inc_c && !pop_c) begin
            afu_cred <= afu_cred + CRED_W'(1);
        end else if (!cred_inc_c && pop_c) begin
            afu_cred <= afu_cred - CRED_W'(1);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_err <= 1'b0;
            credit_err   <= 1'b0;
        end else begin
            if (ovf_c)      overflow_err <= 1'b1;
            if (cred_sat_c) credit_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_oc4_vc_credit_bridge.sv
// Directed bench for oc4_vc_credit_bridge (DATA_W=128, DEPTH=8, CRED_W=7).
module tb_oc4_vc_credit_bridge;

    logic         clock;
    logic         reset;
    logic         tlx_bb_valid;
    logic [127:0] tlx_bb_payload;
    logic [6:0]   bb_tlx_initial_credit;
    logic         bb_tlx_credit;
    logic [6:0]   afu_bb_initial_credit;
    logic         afu_bb_credit;
    logic         bb_afu_valid;
    logic [127:0] bb_afu_payload;
    logic         cfg_resync_credits;
    logic [3:0]   fifo_count;
    logic         overflow_err;
    logic         credit_err;

    int checks;
    int errors;

    oc4_vc_credit_bridge #(.DATA_W(128), .DEPTH(8), .CRED_W(7)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .tlx_bb_valid          (tlx_bb_valid),
        .tlx_bb_payload        (tlx_bb_payload),
        .bb_tlx_initial_credit (bb_tlx_initial_credit),
        .bb_tlx_credit         (bb_tlx_credit),
        .afu_bb_initial_credit (afu_bb_initial_credit),
        .afu_bb_credit         (afu_bb_credit),
        .bb_afu_valid          (bb_afu_valid),
        .bb_afu_payload        (bb_afu_payload),
        .cfg_resync_credits    (cfg_resync_credits),
        .fifo_count            (fifo_count),
        .overflow_err          (overflow_err),
        .credit_err            (credit_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic         v;
        logic [127:0] p;
        logic         cr;
        logic         ev;
        logic [127:0] ep;
        logic [3:0]   ecnt;
        logic         etc;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset, release, then pass through IDLE and LOAD so the next cycle is RUN
    task automatic do_reset(input logic [6:0] init_cred);
        reset                 = 1'b1;
        tlx_bb_valid          = 1'b0;
        tlx_bb_payload        = '0;
        afu_bb_credit         = 1'b0;
        cfg_resync_credits    = 1'b0;
        afu_bb_initial_credit = init_cred;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("cred_after_load", 128'(dut.afu_cred), 128'(init_cred));
    endtask

    initial begin
        logic [127:0] got [$];
        int           pulses;
        int           issues;
        logic [127:0] first_pl;

        checks = 0;
        errors = 0;

        tbl[0] = '{1'b1, 128'hA1, 1'b0, 1'b0, 128'h0,  4'd1, 1'b0};
        tbl[1] = '{1'b1, 128'hA2, 1'b0, 1'b1, 128'hA1, 4'd1, 1'b1};
        tbl[2] = '{1'b1, 128'hA3, 1'b0, 1'b1, 128'hA2, 4'd1, 1'b1};
        tbl[3] = '{1'b1, 128'hA4, 1'b0, 1'b1, 128'hA3, 4'd1, 1'b1};
        tbl[4] = '{1'b1, 128'hA5, 1'b0, 1'b0, 128'hA3, 4'd2, 1'b0};
        tbl[5] = '{1'b0, 128'h0,  1'b0, 1'b0, 128'hA3, 4'd2, 1'b0};
        tbl[6] = '{1'b0, 128'h0,  1'b1, 1'b0, 128'hA3, 4'd2, 1'b0};
        tbl[7] = '{1'b0, 128'h0,  1'b1, 1'b1, 128'hA4, 4'd1, 1'b1};
        tbl[8] = '{1'b0, 128'h0,  1'b0, 1'b1, 128'hA5, 4'd0, 1'b1};
        tbl[9] = '{1'b0, 128'h0,  1'b0, 1'b0, 128'hA5, 4'd0, 1'b0};

        // Reset values while reset is held
        reset = 1'b1;
        tlx_bb_valid = 1'b0; tlx_bb_payload = '0; afu_bb_credit = 1'b0;
        cfg_resync_credits = 1'b0; afu_bb_initial_credit = 7'd3;
        tick();
        chk("rst_valid", 128'(bb_afu_valid), 128'(0));
        chk("rst_payload", bb_afu_payload, 128'h0);
        chk("rst_count", 128'(fifo_count), 128'(0));
        chk("rst_tcred", 128'(bb_tlx_credit), 128'(0));
        chk("rst_init_cred", 128'(bb_tlx_initial_credit), 128'(8));
        chk("rst_ovf", 128'(overflow_err), 128'(0));
        chk("rst_cerr", 128'(credit_err), 128'(0));

        // Test 1: 3 credits, 5 pushes, then two credit returns
        do_reset(7'd3);
        for (int i = 0; i < 10; i++) begin
            tlx_bb_valid   = tbl[i].v;
            tlx_bb_payload = tbl[i].p;
            afu_bb_credit  = tbl[i].cr;
            tick();
            chk($sformatf("t1_valid[%0d]", i), 128'(bb_afu_valid), 128'(tbl[i].ev));
            chk($sformatf("t1_payload[%0d]", i), bb_afu_payload, tbl[i].ep);
            chk($sformatf("t1_count[%0d]", i), 128'(fifo_count), 128'(tbl[i].ecnt));
            chk($sformatf("t1_tcred[%0d]", i), 128'(bb_tlx_credit), 128'(tbl[i].etc));
            chk($sformatf("t1_ovf[%0d]", i), 128'(overflow_err), 128'(0));
        end

        // Test 2: no AFU credit, 9 pushes overflow on the last
        do_reset(7'd0);
        for (int i = 1; i <= 9; i++) begin
            tlx_bb_valid   = 1'b1;
            tlx_bb_payload = 128'hB00 + 128'(i);
            tick();
            chk($sformatf("t2_count[%0d]", i), 128'(fifo_count), 128'((i > 8) ? 8 : i));
            chk($sformatf("t2_ovf[%0d]", i), 128'(overflow_err), 128'((i == 9) ? 1 : 0));
            chk($sformatf("t2_tcred[%0d]", i), 128'(bb_tlx_credit), 128'(0));
        end
        tlx_bb_valid = 1'b0;
        pulses = 0;
        got.delete();
        for (int k = 0; k < 12; k++) begin
            afu_bb_credit = (k < 9);
            tick();
            if (bb_afu_valid) got.push_back(bb_afu_payload);
            if (bb_tlx_credit) pulses++;
        end
        afu_bb_credit = 1'b0;
        chk("t2_drain_n", 128'(got.size()), 128'(8));
        for (int i = 0; i < got.size() && i < 8; i++) begin
            chk($sformatf("t2_drain[%0d]", i), got[i], 128'hB00 + 128'(i + 1));
        end
        chk("t2_pulses", 128'(pulses), 128'(8));
        chk("t2_count_end", 128'(fifo_count), 128'(0));

        // Test 3: push onto a full FIFO in the same cycle as a pop
        do_reset(7'd0);
        for (int i = 1; i <= 8; i++) begin
            tlx_bb_valid = 1'b1; tlx_bb_payload = 128'hD00 + 128'(i);
            tick();
        end
        tlx_bb_valid = 1'b0; afu_bb_credit = 1'b1;
        tick();
        chk("t3_count_pre", 128'(fifo_count), 128'(8));
        chk("t3_tcred_pre", 128'(bb_tlx_credit), 128'(0));
        for (int i = 1; i <= 3; i++) begin
            tlx_bb_valid = 1'b1; tlx_bb_payload = 128'hE00 + 128'(i);
            tick();
            chk($sformatf("t3_count[%0d]", i), 128'(fifo_count), 128'(8));
            chk($sformatf("t3_ovf[%0d]", i), 128'(overflow_err), 128'(0));
            chk($sformatf("t3_tcred[%0d]", i), 128'(bb_tlx_credit), 128'(1));
            chk($sformatf("t3_payload[%0d]", i), bb_afu_payload, 128'hD00 + 128'(i));
        end
        tlx_bb_valid = 1'b0; afu_bb_credit = 1'b0;
        tick();
        chk("t3_count_last", 128'(fifo_count), 128'(7));
        chk("t3_tcred_last", 128'(bb_tlx_credit), 128'(1));
        tick();
        chk("t3_tcred_idle", 128'(bb_tlx_credit), 128'(0));
        chk("t3_ovf_end", 128'(overflow_err), 128'(0));

        // Test 4: resync hold blocks issue, release reloads to 1 credit
        do_reset(7'd4);
        for (int i = 0; i < 5; i++) begin
            cfg_resync_credits = 1'b1;
            tlx_bb_valid       = (i == 1) || (i == 2);
            tlx_bb_payload     = 128'hF00 + 128'(i);
            tick();
            chk($sformatf("t4_hold_valid[%0d]", i), 128'(bb_afu_valid), 128'(0));
        end
        tlx_bb_valid = 1'b0;
        chk("t4_hold_count", 128'(fifo_count), 128'(2));
        chk("t4_hold_cred", 128'(dut.afu_cred), 128'(4));
        cfg_resync_credits = 1'b0; afu_bb_initial_credit = 7'd1;
        tick();
        chk("t4_load_valid", 128'(bb_afu_valid), 128'(0));
        tick();
        chk("t4_reload_cred", 128'(dut.afu_cred), 128'(1));
        issues = 0; first_pl = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bb_afu_valid) begin
                if (issues == 0) first_pl = bb_afu_payload;
                issues++;
            end
        end
        chk("t4_issues", 128'(issues), 128'(1));
        chk("t4_payload", first_pl, 128'hF01);
        chk("t4_count_end", 128'(fifo_count), 128'(1));

        // Test 5: saturation of the AFU credit counter at 127
        do_reset(7'd127);
        tlx_bb_valid = 1'b1; tlx_bb_payload = 128'h601;
        tick();
        tlx_bb_valid = 1'b0; afu_bb_credit = 1'b1;
        tick();
        chk("t5_issue_valid", 128'(bb_afu_valid), 128'(1));
        chk("t5_issue_cred", 128'(dut.afu_cred), 128'(127));
        chk("t5_issue_cerr", 128'(credit_err), 128'(0));
        tick();
        afu_bb_credit = 1'b0;
        chk("t5_sat_cerr", 128'(credit_err), 128'(1));
        chk("t5_sat_cred", 128'(dut.afu_cred), 128'(127));

        // Test 6: asynchronous reset mid-operation, no stale payload afterwards
        do_reset(7'd0);
        for (int i = 1; i <= 4; i++) begin
            tlx_bb_valid = 1'b1; tlx_bb_payload = 128'h700 + 128'(i);
            tick();
        end
        tlx_bb_valid = 1'b0; afu_bb_credit = 1'b1;
        tick();
        afu_bb_credit = 1'b0;
        tick();
        chk("t6_pre_valid", 128'(bb_afu_valid), 128'(1));
        chk("t6_pre_count", 128'(fifo_count), 128'(3));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", 128'(bb_afu_valid), 128'(0));
        chk("t6_async_payload", bb_afu_payload, 128'h0);
        chk("t6_async_count", 128'(fifo_count), 128'(0));
        chk("t6_async_tcred", 128'(bb_tlx_credit), 128'(0));
        chk("t6_async_init", 128'(bb_tlx_initial_credit), 128'(8));
        tick();
        afu_bb_initial_credit = 7'd2;
        reset = 1'b0;
        tick();
        chk("t6_idle_to_load_cred", 128'(dut.afu_cred), 128'(0));
        tick();
        chk("t6_load_cred", 128'(dut.afu_cred), 128'(2));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t6_stale_valid[%0d]", k), 128'(bb_afu_valid), 128'(0));
        end
        chk("t6_count_empty", 128'(fifo_count), 128'(0));
        tlx_bb_valid = 1'b1; tlx_bb_payload = 128'h801;
        tick();
        tlx_bb_valid = 1'b0;
        chk("t6_new_lat1", 128'(bb_afu_valid), 128'(0));
        tick();
        chk("t6_new_valid", 128'(bb_afu_valid), 128'(1));
        chk("t6_new_payload", bb_afu_payload, 128'h801);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
